// File: rtl/rv_encoder_if.sv
// Request/stream bundle between the program loader and rv_encoder.
// Latency: none (wires only).
// Backpressure: in_ready_o throttles requests, out_ready_i throttles the word stream.
// Ports (signals):
//   in_valid_i/in_ready_o         request handshake
//   op_i, rd_i, rs1_i, rs2_i, imm_i  instruction fields
//   out_valid_o/out_ready_i       encoded word handshake
//   out_instr_o, out_addr_o       encoded word and its imem byte address
interface rv_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [3:0]        op_i;
  logic [4:0]        rd_i;
  logic [4:0]        rs1_i;
  logic [4:0]        rs2_i;
  logic [31:0]       imm_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       out_instr_o;
  logic [ADDR_W-1:0] out_addr_o;

  // Encoder side
  modport slave (
    input  in_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i, out_ready_i,
    output in_ready_o, out_valid_o, out_instr_o, out_addr_o
  );

  // Loader / imem-writer side
  modport master (
    output in_valid_i, op_i, rd_i, rs1_i, rs2_i, imm_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_instr_o, out_addr_o
  );
endinterface

// File: rtl/rv_encoder.sv
// Encodes field-level requests into RV32I words (ADD SUB AND OR ADDI LW SW BEQ LUI) and streams them with imem addresses.
// Latency: one cycle from accept to out_* when the FIFO is empty.
// Backpressure: in_ready_o drops when DEPTH words are buffered; words hold at the head until out_ready_i.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   bus            rv_encoder_if.slave: request handshake + fields, word stream + address
//   addr_clr_i     reload the address counter to BASE_ADDR (wins over a same-cycle pop)
//   err_o          one-cycle pulse after a rejected (handshaken but not pushed) request
//   level_o        FIFO occupancy
module rv_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  rv_encoder_if.slave            bus,
  input  logic                   addr_clr_i,
  output logic                   err_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_S  = 7'b0100011;
  localparam logic [6:0] OPC_B  = 7'b1100011;
  localparam logic [6:0] OPC_U  = 7'b0110111;

  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  assign imm = bus.imm_i;
  assign rd  = bus.rd_i;
  assign rs1 = bus.rs1_i;
  assign rs2 = bus.rs2_i;

  // ---------------------------------------------------------------- encoder
  logic [31:0] enc_instr;
  logic        enc_bad;
  logic        imm12_fits;   // sign-extended 12-bit range [-2048, 2047]
  logic        imm13_fits;   // even and within [-4096, 4094]

  // A value fits in N signed bits when every bit from N-1 upward equals the sign.
  assign imm12_fits = (&imm[31:11]) | ~(|imm[31:11]);
  assign imm13_fits = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];

  always_comb begin
    enc_instr = '0;
    enc_bad   = 1'b0;
    case (bus.op_i)
      4'd0: enc_instr = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
      4'd1: enc_instr = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R};
      4'd2: enc_instr = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R};
      4'd3: enc_instr = {7'b0000000, rs2, rs1, 3'b110, rd, OPC_R};
      4'd4: begin
        enc_instr = {imm[11:0], rs1, 3'b000, rd, OPC_I};
        enc_bad   = ~imm12_fits;
      end
      4'd5: begin
        enc_instr = {imm[11:0], rs1, 3'b010, rd, OPC_LD};
        enc_bad   = ~imm12_fits;
      end
      4'd6: begin
        enc_instr = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_S};
        enc_bad   = ~imm12_fits;
      end
      4'd7: begin
        enc_instr = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_B};
        enc_bad   = ~imm13_fits;
      end
      4'd8: enc_instr = {imm[31:12], rd, OPC_U};
      default: enc_bad = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- FIFO
  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic in_ready, out_valid, accept, push, pop;

  // No bypass at full: a pop in the same cycle does not open a slot.
  assign in_ready  = (level_q != FULL_LVL);
  assign out_valid = (level_q != '0);
  assign accept    = bus.in_valid_i & in_ready;
  assign push      = accept & ~enc_bad;
  assign pop       = out_valid & bus.out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    addr_d   = addr_q;
    err_d    = accept & enc_bad;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    if (addr_clr_i)  addr_d = BASE_ADDR;
    else if (pop)    addr_d = addr_q + ADDR_W'(4);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= enc_instr;
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_instr_o = out_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign bus.out_addr_o  = addr_q;
  assign err_o           = err_q;
  assign level_o         = level_q;

endmodule

// File: tb/tb_rv_encoder.sv
// Bench for rv_encoder: directed vectors plus a randomized run against a queue-based reference model.
// Latency: model expects pushed words at the head one cycle after accept.
// Backpressure: model tracks full/empty and the address counter independently of the RTL.
module tb_rv_encoder;
  localparam int          DEPTH = 4;
  localparam int          AW    = 32;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic       clk = 1'b0;
  logic       rst;
  logic       addr_clr;
  logic       err;
  logic [2:0] level;

  int checks   = 0;
  int failures = 0;

  rv_encoder_if #(.ADDR_W(AW)) bus ();

  rv_encoder #(.DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .addr_clr_i (addr_clr),
    .err_o      (err),
    .level_o    (level)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------ reference model
  logic [31:0] exp_q[$];
  logic [31:0] m_addr;
  bit          m_err;

  // Builds the word by adding shifted field values; legality from signed range checks.
  function automatic void ref_enc(input logic [31:0] op, input logic [31:0] rd,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] imm, output bit ok, output logic [31:0] w);
    int s;
    s  = $signed(imm);
    ok = 1'b1;
    w  = 32'h0;
    case (op)
      0: w = 32'h33 + (rd << 7) + (rs1 << 15) + (rs2 << 20);
      1: w = 32'h33 + (rd << 7) + (rs1 << 15) + (rs2 << 20) + 32'h4000_0000;
      2: w = 32'h33 + (rd << 7) + (7 << 12) + (rs1 << 15) + (rs2 << 20);
      3: w = 32'h33 + (rd << 7) + (6 << 12) + (rs1 << 15) + (rs2 << 20);
      4, 5: begin
        if (s < -2048 || s > 2047) ok = 1'b0;
        else w = ((op == 4) ? 32'h13 : (32'h03 + (2 << 12))) + (rd << 7) + (rs1 << 15)
                 + ((imm & 32'hFFF) << 20);
      end
      6: begin
        if (s < -2048 || s > 2047) ok = 1'b0;
        else w = 32'h23 + (2 << 12) + ((imm & 31) << 7) + (rs1 << 15) + (rs2 << 20)
                 + (((imm >> 5) & 127) << 25);
      end
      7: begin
        if (s < -4096 || s > 4094 || (s % 2) != 0) ok = 1'b0;
        else w = 32'h63 + (((imm >> 11) & 1) << 7) + (((imm >> 1) & 15) << 8)
                 + (rs1 << 15) + (rs2 << 20) + (((imm >> 5) & 63) << 25)
                 + (((imm >> 12) & 1) << 31);
      end
      8: w = 32'h37 + (rd << 7) + (imm & 32'hFFFF_F000);
      default: ok = 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance model, clock, compare every output with the model.
  task automatic step(input bit r, input bit vld, input logic [3:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input bit rdy, input bit clr);
    bit          ok, acc, pp;
    logic [31:0] w;
    rst             = r;
    bus.in_valid_i  = vld;
    bus.op_i        = op;
    bus.rd_i        = rd;
    bus.rs1_i       = rs1;
    bus.rs2_i       = rs2;
    bus.imm_i       = imm;
    bus.out_ready_i = rdy;
    addr_clr        = clr;
    ref_enc(32'(op), 32'(rd), 32'(rs1), 32'(rs2), imm, ok, w);
    if (r) begin
      exp_q.delete();
      m_addr = BASE;
      m_err  = 1'b0;
    end else begin
      acc = vld && (exp_q.size() != DEPTH);
      pp  = rdy && (exp_q.size() != 0);
      if (pp) void'(exp_q.pop_front());
      if (acc && ok) exp_q.push_back(w);
      if (clr) m_addr = BASE;
      else if (pp) m_addr = m_addr + 32'd4;
      m_err = acc && !ok;
    end
    @(posedge clk);
    #1;
    rst             = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    addr_clr        = 1'b0;
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("in_ready", 32'(bus.in_ready_o), 32'(exp_q.size() != DEPTH));
    chk("out_valid", 32'(bus.out_valid_o), 32'(exp_q.size() != 0));
    chk("out_instr", bus.out_instr_o, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
    chk("out_addr", bus.out_addr_o, m_addr);
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    step(1'b0, 1'b1, op, rd, rs1, rs2, imm, 1'b0, 1'b0);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b0);
  endtask

  logic [31:0] fill_words [4] = '{32'h407302B3, 32'hFFF00093, 32'h12345137, 32'h00312423};
  int          bnd [10] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098, 4096, 3};

  initial begin
    logic [31:0] imm;
    rst             = 1'b1;
    addr_clr        = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.op_i        = '0;
    bus.rd_i        = '0;
    bus.rs1_i       = '0;
    bus.rs2_i       = '0;
    bus.imm_i       = '0;
    m_addr          = BASE;
    m_err           = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd0, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 1'b0);
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_instr", bus.out_instr_o, 32'h0);
    chk("rst_addr", bus.out_addr_o, BASE);
    chk("rst_level", 32'(level), 32'd0);

    // ADD x1,x2,x3 visible one cycle after accept
    push(4'd0, 5'd1, 5'd2, 5'd3, 32'h0);
    chk("add_word", bus.out_instr_o, 32'h003100B3);
    chk("add_addr", bus.out_addr_o, BASE);
    pop();
    chk("addr_after_pop", bus.out_addr_o, BASE + 32'd4);
    step(1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b1);
    chk("addr_clr", bus.out_addr_o, BASE);

    // Fill to DEPTH with no consumer, then one more attempt while full
    push(4'd1, 5'd5, 5'd6, 5'd7, 32'h0);
    push(4'd4, 5'd1, 5'd0, 5'd9, 32'hFFFF_FFFF);
    push(4'd8, 5'd2, 5'd0, 5'd0, 32'h1234_5000);
    push(4'd6, 5'd0, 5'd2, 5'd3, 32'd8);
    chk("full_level", 32'(level), 32'(DEPTH));
    chk("full_in_ready", 32'(bus.in_ready_o), 32'd0);
    push(4'd0, 5'd9, 5'd9, 5'd9, 32'h0);
    chk("full_hold", 32'(level), 32'(DEPTH));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_word%0d", i), bus.out_instr_o, fill_words[i]);
      chk($sformatf("drain_addr%0d", i), bus.out_addr_o, BASE + 32'(4 * i));
      pop();
    end

    // BEQ x1,x2,-8 and LW x4,4(x1)
    push(4'd7, 5'd0, 5'd1, 5'd2, -32'sd8);
    chk("beq_word", bus.out_instr_o, 32'hFE208CE3);
    pop();
    push(4'd5, 5'd4, 5'd1, 5'd0, 32'd4);
    chk("lw_word", bus.out_instr_o, 32'h0040A203);
    pop();

    // Rejected requests: illegal op, ADDI out of range, odd BEQ offset
    push(4'd9, 5'd1, 5'd1, 5'd1, 32'h0);
    chk("illop_err", 32'(err), 32'd1);
    chk("illop_level", 32'(level), 32'd0);
    idle();
    chk("illop_err_clear", 32'(err), 32'd0);
    push(4'd4, 5'd1, 5'd0, 5'd0, 32'd2048);
    chk("addi2048_err", 32'(err), 32'd1);
    chk("addi2048_level", 32'(level), 32'd0);
    idle();
    push(4'd7, 5'd0, 5'd1, 5'd2, 32'd6);
    push(4'd7, 5'd0, 5'd1, 5'd2, 32'd5);
    chk("beq_odd_err", 32'(err), 32'd1);
    chk("beq_even_level", 32'(level), 32'd1);
    pop();

    // Push+pop at level 2, then clear with pop
    push(4'd2, 5'd3, 5'd4, 5'd5, 32'h0);
    push(4'd3, 5'd6, 5'd7, 5'd8, 32'h0);
    step(1'b0, 1'b1, 4'd0, 5'd9, 5'd10, 5'd11, 32'h0, 1'b1, 1'b0);
    chk("pushpop_level", 32'(level), 32'd2);
    step(1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 1'b1);
    chk("clr_wins_addr", bus.out_addr_o, BASE);
    chk("clr_pop_level", 32'(level), 32'd1);
    pop();

    // Randomized traffic, with a mid-stream reset
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        2:       imm = 32'(bnd[$urandom_range(0, 9)]);
        default: imm = 32'($urandom_range(0, 8190)) - 32'd4096;
      endcase
      step(n == 300, ($urandom % 4) != 0, 4'($urandom_range(0, 10)), 5'($urandom),
           5'($urandom), 5'($urandom), imm,
           (n < 150) ? (($urandom % 3) == 0) : (($urandom % 3) != 0),
           ($urandom % 16) == 0);
    end
    while (exp_q.size() != 0) pop();
    chk("final_level", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
